// File: rtl/bsg_bp_mc_responder_pkg.sv
// Shared types for the manycore link responder: packet formats, FSM states,
// index width and AMO helpers. AMO support is enabled by BSG_BP_MC_RESPONDER_AMO_EN.
package bsg_bp_mc_responder_pkg;

    localparam int unsigned mc_addr_width_gp    = 28;
    localparam int unsigned mc_data_width_gp    = 32;
    localparam int unsigned mc_x_cord_width_gp  = 7;
    localparam int unsigned mc_y_cord_width_gp  = 7;
    localparam int unsigned mc_reg_id_width_gp  = 5;
    localparam int unsigned mc_mask_width_gp    = mc_data_width_gp / 8;
    localparam int unsigned els_gp              = 64;
    localparam int unsigned idx_width_gp        = $clog2(els_gp);
    localparam int unsigned err_cnt_width_gp    = 16;

    typedef enum logic [2:0] {
        e_op_load    = 3'd0,
        e_op_store   = 3'd1,
        e_op_amoswap = 3'd2,
        e_op_amoadd  = 3'd3,
        e_op_amoor   = 3'd4,
        e_op_amoand  = 3'd5
    } mc_op_e;

    typedef enum logic [1:0] {
        e_return_credit = 2'd0,
        e_return_int_wb = 2'd1
    } mc_ret_e;

    typedef enum logic [1:0] {
        eIdle   = 2'd0,
        eAccess = 2'd1,
        eAmoWr  = 2'd2,
        eResp   = 2'd3
    } state_e;

    typedef struct packed {
        logic [mc_addr_width_gp-1:0]   addr;
        mc_op_e                        op;
        logic [mc_mask_width_gp-1:0]   mask;
        logic [mc_reg_id_width_gp-1:0] reg_id;
        logic [mc_data_width_gp-1:0]   data;
        logic [mc_y_cord_width_gp-1:0] src_y;
        logic [mc_x_cord_width_gp-1:0] src_x;
        logic [mc_y_cord_width_gp-1:0] dst_y;
        logic [mc_x_cord_width_gp-1:0] dst_x;
    } fwd_pkt_s;

    // y_cord/x_cord route the response back; from_* identify this responder
    typedef struct packed {
        mc_ret_e                       ret_type;
        logic [mc_data_width_gp-1:0]   data;
        logic [mc_reg_id_width_gp-1:0] reg_id;
        logic [mc_y_cord_width_gp-1:0] y_cord;
        logic [mc_x_cord_width_gp-1:0] x_cord;
        logic [mc_y_cord_width_gp-1:0] from_y;
        logic [mc_x_cord_width_gp-1:0] from_x;
    } rev_pkt_s;

    function automatic logic is_amo(input mc_op_e op);
        return (op == e_op_amoswap) || (op == e_op_amoadd)
            || (op == e_op_amoor)   || (op == e_op_amoand);
    endfunction

    function automatic logic [mc_data_width_gp-1:0] amo_apply(
        input mc_op_e                      op,
        input logic [mc_data_width_gp-1:0] old_v,
        input logic [mc_data_width_gp-1:0] operand);
        case (op)
            e_op_amoswap: return operand;
            e_op_amoadd:  return old_v + operand;
            e_op_amoor:   return old_v | operand;
            e_op_amoand:  return old_v & operand;
            default:      return old_v;
        endcase
    endfunction

endpackage

// File: rtl/bsg_bp_mc_link_responder_if.sv
// Forward request / reverse response channel pair of one manycore proc link.
interface bsg_bp_mc_link_responder_if;
    import bsg_bp_mc_responder_pkg::*;

    logic     fwd_v;
    fwd_pkt_s fwd_data;
    logic     fwd_ready;
    logic     rev_v;
    rev_pkt_s rev_data;
    logic     rev_ready;

    modport master (output fwd_v, fwd_data, rev_ready,
                    input  fwd_ready, rev_v, rev_data);
    modport slave  (input  fwd_v, fwd_data, rev_ready,
                    output fwd_ready, rev_v, rev_data);
endinterface

// File: rtl/bsg_bp_mc_responder_mem.sv
// Word-addressed scratch memory: synchronous read, byte-masked write.
// data_o only changes on a read, so it holds the last read value.
module bsg_bp_mc_responder_mem #(
    parameter int unsigned els_p        = 64,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned idx_width_p  = 6
) (
    input  logic                      clk_i,
    input  logic                      v_i,
    input  logic                      w_i,
    input  logic [idx_width_p-1:0]    addr_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [data_width_p/8-1:0] mask_i,
    output logic [data_width_p-1:0]   data_o
);
    localparam int unsigned mask_width_lp = data_width_p / 8;

    logic [data_width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                for (int b = 0; b < mask_width_lp; b++) begin
                    if (mask_i[b]) mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
            end else begin
                data_o <= mem_r[addr_i];
            end
        end
    end
endmodule

// File: rtl/bsg_bp_mc_link_responder.sv
// Manycore target endpoint: queues forward requests, accesses the scratch
// memory and returns one response per request. AMOs need BSG_BP_MC_RESPONDER_AMO_EN.
module bsg_bp_mc_link_responder
    import bsg_bp_mc_responder_pkg::*;
#(
    parameter int unsigned els_p           = els_gp,
    parameter int unsigned err_cnt_width_p = err_cnt_width_gp
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    bsg_bp_mc_link_responder_if.slave         link_sif,
    input  logic [mc_x_cord_width_gp-1:0]     global_x_i,
    input  logic [mc_y_cord_width_gp-1:0]     global_y_i,
    output logic [err_cnt_width_p-1:0]        err_count_o,
    output logic                              busy_o
);
    localparam int unsigned lg_els_lp = $clog2(els_p);

    // two-entry ingress fifo; the head stays queued until its response is taken
    fwd_pkt_s   fifo_mem [2];
    logic       wr_ptr_r, rd_ptr_r;
    logic [1:0] fifo_cnt_r, fifo_cnt_next_c;
    logic       fwd_ready_r;
    logic       enq_c, deq_c, fifo_v_c;

    state_e     state_r;
    fwd_pkt_s   pkt_r;
    logic       bad_r, rev_v_r, busy_r;
    logic [err_cnt_width_p-1:0] err_cnt_r;

    logic       oor_c, supported_c, bad_c, amo_go_c;
    logic                        mem_v_c, mem_w_c;
    logic [mc_data_width_gp-1:0] mem_data_c, mem_q;
    logic [mc_mask_width_gp-1:0] mem_mask_c;
    rev_pkt_s   rev_data_c;
    logic       unused_dst;

    assign enq_c           = link_sif.fwd_v & fwd_ready_r;
    assign deq_c           = rev_v_r & link_sif.rev_ready;
    assign fifo_v_c        = (fifo_cnt_r != 2'd0);
    assign fifo_cnt_next_c = fifo_cnt_r + 2'(enq_c) - 2'(deq_c);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            fifo_cnt_r  <= 2'd0;
            fwd_ready_r <= 1'b0;
        end else begin
            if (enq_c) begin
                fifo_mem[wr_ptr_r] <= link_sif.fwd_data;
                wr_ptr_r           <= ~wr_ptr_r;
            end
            if (deq_c) rd_ptr_r <= ~rd_ptr_r;
            fifo_cnt_r  <= fifo_cnt_next_c;
            fwd_ready_r <= (fifo_cnt_next_c != 2'd2);
        end
    end

    assign oor_c = (pkt_r.addr[mc_addr_width_gp-1:lg_els_lp] != '0);
`ifdef BSG_BP_MC_RESPONDER_AMO_EN
    assign supported_c = (pkt_r.op == e_op_load) | (pkt_r.op == e_op_store) | is_amo(pkt_r.op);
    assign amo_go_c    = is_amo(pkt_r.op) & ~oor_c;
`else
    assign supported_c = (pkt_r.op == e_op_load) | (pkt_r.op == e_op_store);
    assign amo_go_c    = 1'b0;
`endif
    assign bad_c = oor_c | ~supported_c;

    // memory port: access in eAccess, read-modify-write completes in eAmoWr
    always_comb begin
        mem_v_c    = 1'b0;
        mem_w_c    = 1'b0;
        mem_data_c = pkt_r.data;
        mem_mask_c = pkt_r.mask;
        if (state_r == eAccess && !bad_c) begin
            mem_v_c = 1'b1;
            mem_w_c = (pkt_r.op == e_op_store);
        end
`ifdef BSG_BP_MC_RESPONDER_AMO_EN
        if (state_r == eAmoWr) begin
            mem_v_c    = 1'b1;
            mem_w_c    = 1'b1;
            mem_data_c = amo_apply(pkt_r.op, mem_q, pkt_r.data);
            mem_mask_c = '1;
        end
`endif
    end

    bsg_bp_mc_responder_mem #(
        .els_p        (els_p),
        .data_width_p (mc_data_width_gp),
        .idx_width_p  (lg_els_lp)
    ) mem (
        .clk_i  (clk_i),
        .v_i    (mem_v_c),
        .w_i    (mem_w_c),
        .addr_i (pkt_r.addr[lg_els_lp-1:0]),
        .data_i (mem_data_c),
        .mask_i (mem_mask_c),
        .data_o (mem_q)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= eIdle;
            pkt_r     <= '0;
            bad_r     <= 1'b0;
            rev_v_r   <= 1'b0;
            busy_r    <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            case (state_r)
                eIdle: begin
                    if (fifo_v_c) begin
                        pkt_r   <= fifo_mem[rd_ptr_r];
                        state_r <= eAccess;
                        busy_r  <= 1'b1;
                    end
                end
                eAccess: begin
                    bad_r <= bad_c;
                    if (bad_c && err_cnt_r != '1)
                        err_cnt_r <= err_cnt_r + err_cnt_width_p'(1);
                    if (amo_go_c) begin
                        state_r <= eAmoWr;
                    end else begin
                        state_r <= eResp;
                        rev_v_r <= 1'b1;
                    end
                end
                eAmoWr: begin
                    state_r <= eResp;
                    rev_v_r <= 1'b1;
                end
                eResp: begin
                    if (link_sif.rev_ready) begin
                        state_r <= eIdle;
                        rev_v_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= eIdle;
                    rev_v_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // response fields come only from flops, so they stay stable while stalled
    always_comb begin
        rev_data_c          = '0;
        rev_data_c.ret_type = (pkt_r.op == e_op_store) ? e_return_credit : e_return_int_wb;
        rev_data_c.data     = (bad_r || pkt_r.op == e_op_store) ? '0 : mem_q;
        rev_data_c.reg_id   = pkt_r.reg_id;
        rev_data_c.y_cord   = pkt_r.src_y;
        rev_data_c.x_cord   = pkt_r.src_x;
        rev_data_c.from_y   = global_y_i;
        rev_data_c.from_x   = global_x_i;
    end

    assign unused_dst         = ^{pkt_r.dst_y, pkt_r.dst_x};
    assign link_sif.fwd_ready = fwd_ready_r;
    assign link_sif.rev_v     = rev_v_r;
    assign link_sif.rev_data  = rev_data_c;
    assign err_count_o        = err_cnt_r;
    assign busy_o             = busy_r;
endmodule
